// File: rtl/legv8_cache_ctrl_if.sv
// legv8_cache_ctrl_if: CPU, cache-array and main-memory signals of the cache controller.
// Revision: 1.0
`default_nettype none

interface legv8_cache_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             cpu_req;
   logic [63:0]      cpu_addr;
   logic             cpu_busy;
   logic             cpu_done;
   logic             cpu_hit;
   logic [4:0]       Index;
   logic [56:0]      Tag;
   logic             hit_status;
   logic             Write0;
   logic             Write1;
   logic             Write2;
   logic             Write3;
   logic             mem_req;
   logic [63:0]      mem_addr;
   logic             mem_ack;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] miss_cnt;

   modport master (
      input  cpu_req, cpu_addr, hit_status, mem_ack,
      output cpu_busy, cpu_done, cpu_hit, Index, Tag,
             Write0, Write1, Write2, Write3,
             mem_req, mem_addr, hit_cnt, miss_cnt
   );

   modport slave (
      output cpu_req, cpu_addr, hit_status, mem_ack,
      input  cpu_busy, cpu_done, cpu_hit, Index, Tag,
             Write0, Write1, Write2, Write3,
             mem_req, mem_addr, hit_cnt, miss_cnt
   );
endinterface

`default_nettype wire

// File: rtl/legv8_cache_ctrl.sv
// legv8_cache_ctrl: lookup/miss-fill controller for a 4-way cache with per-index round-robin replacement.
// Revision: 1.0
`default_nettype none

module legv8_cache_ctrl #(
   parameter int CNT_W   = 16,
   parameter int NUM_IDX = 32
) (
   input  wire logic          clk,
   input  wire logic          rst,
   legv8_cache_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOOKUP   = 3'd1,
      S_MISS_REQ = 3'd2,
      S_FILL     = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next;
   // Only the block address is kept; the byte offset is never used.
   logic [61:0]      r_blk;
   logic             r_hit;
   logic [CNT_W-1:0] r_hit_cnt;
   logic [CNT_W-1:0] r_miss_cnt;
   logic [1:0]       r_rr [NUM_IDX];

   logic [4:0]       w_idx;
   logic [1:0]       w_way;
   logic [3:0]       w_wr;
   logic             w_busy;
   logic             w_done;
   logic             w_mreq;

   assign w_idx = r_blk[4:0];
   assign w_way = r_rr[w_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b1;
      w_done = 1'b0;
      w_mreq = 1'b0;
      w_wr   = 4'b0000;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.cpu_req) w_next = S_LOOKUP;
         end
         S_LOOKUP:   w_next = bus.hit_status ? S_DONE : S_MISS_REQ;
         S_MISS_REQ: begin
            w_mreq = 1'b1;
            if (bus.mem_ack) w_next = S_FILL;
         end
         S_FILL: begin
            w_wr[w_way] = 1'b1;
            w_next      = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blk      <= '0;
         r_hit      <= 1'b0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         for (int i = 0; i < NUM_IDX; i++) r_rr[i] <= 2'd0;
      end else begin
         if (r_state == S_IDLE && bus.cpu_req) r_blk <= bus.cpu_addr[63:2];
         if (r_state == S_LOOKUP) begin
            if (bus.hit_status) begin
               r_hit <= 1'b1;
               if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
            end else begin
               if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
            end
         end
         if (r_state == S_FILL) begin
            r_hit        <= 1'b0;
            r_rr[w_idx]  <= w_way + 2'd1;
         end
      end
   end

   assign bus.cpu_busy = w_busy;
   assign bus.cpu_done = w_done;
   assign bus.cpu_hit  = r_hit;
   assign bus.Index    = w_idx;
   assign bus.Tag      = r_blk[61:5];
   assign bus.Write0   = w_wr[0];
   assign bus.Write1   = w_wr[1];
   assign bus.Write2   = w_wr[2];
   assign bus.Write3   = w_wr[3];
   assign bus.mem_req  = w_mreq;
   assign bus.mem_addr = {r_blk, 2'b00};
   assign bus.hit_cnt  = r_hit_cnt;
   assign bus.miss_cnt = r_miss_cnt;
endmodule

`default_nettype wire

// File: tb/tb_legv8_cache_ctrl.sv
// tb_legv8_cache_ctrl: directed and randomized checks of legv8_cache_ctrl against a transaction-level model.
// Revision: 1.0
`default_nettype none

module tb_legv8_cache_ctrl;
   localparam int CMAX = 65535;

   logic clk;
   logic rst;
   int   ncmp;
   int   nfail;

   // Transaction-level reference state.
   int   m_rr [32];
   int   m_hit;
   int   m_miss;

   legv8_cache_ctrl_if #(.CNT_W(16)) bus ();
   legv8_cache_ctrl_if #(.CNT_W(2))  bus2 ();

   legv8_cache_ctrl #(.CNT_W(16), .NUM_IDX(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   legv8_cache_ctrl #(.CNT_W(2), .NUM_IDX(32)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] wr_vec();
      return {bus.Write3, bus.Write2, bus.Write1, bus.Write0};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rr[i] = 0;
      m_hit  = 0;
      m_miss = 0;
   endtask

   // One request from IDLE; called at a falling edge with the FSM idle.
   task automatic txn(input logic [63:0] a, input bit h, input int d, input bit noise);
      int         idx;
      int         way;
      logic [3:0] exp_wr;
      idx = int'(a[6:2]);
      bus.cpu_addr   = a;
      bus.cpu_req    = 1'b1;
      bus.hit_status = h;
      chk("idle_busy", bus.cpu_busy, 1'b0);
      @(negedge clk);
      bus.cpu_req = noise;
      bus.mem_ack = noise;
      chk("lookup_busy", bus.cpu_busy, 1'b1);
      chk("lookup_index", bus.Index, a[6:2]);
      chk("lookup_tag", bus.Tag, a[63:7]);
      chk("lookup_done", bus.cpu_done, 1'b0);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      bus.mem_ack = 1'b0;
      if (h) begin
         m_hit = (m_hit < CMAX) ? m_hit + 1 : CMAX;
         chk("hit_done", bus.cpu_done, 1'b1);
         chk("hit_flag", bus.cpu_hit, 1'b1);
         chk("hit_no_write", wr_vec(), 4'b0000);
         chk("hit_no_memreq", bus.mem_req, 1'b0);
         chk("hit_cnt", bus.hit_cnt, m_hit);
         chk("hit_misscnt", bus.miss_cnt, m_miss);
      end else begin
         m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
         chk("miss_memaddr", bus.mem_addr, {a[63:2], 2'b00});
         chk("miss_cnt", bus.miss_cnt, m_miss);
         for (int k = 0; k < d; k++) begin
            chk("wait_memreq", bus.mem_req, 1'b1);
            chk("wait_no_write", wr_vec(), 4'b0000);
            bus.cpu_req = noise && (k == 0);
            @(negedge clk);
            bus.cpu_req = 1'b0;
         end
         chk("ack_memreq", bus.mem_req, 1'b1);
         bus.mem_ack = 1'b1;
         @(negedge clk);
         bus.mem_ack = 1'b0;
         way        = m_rr[idx];
         m_rr[idx]  = (way + 1) % 4;
         exp_wr     = 4'b0001 << way;
         chk("fill_write", wr_vec(), exp_wr);
         chk("fill_memreq", bus.mem_req, 1'b0);
         chk("fill_done", bus.cpu_done, 1'b0);
         @(negedge clk);
         chk("miss_done", bus.cpu_done, 1'b1);
         chk("miss_flag", bus.cpu_hit, 1'b0);
         chk("done_no_write", wr_vec(), 4'b0000);
         chk("miss_hitcnt", bus.hit_cnt, m_hit);
      end
      @(negedge clk);
      chk("after_busy", bus.cpu_busy, 1'b0);
      chk("after_done", bus.cpu_done, 1'b0);
      chk("after_hit_hold", bus.cpu_hit, h);
   endtask

   initial begin
      logic [63:0] a;
      ncmp  = 0;
      nfail = 0;
      model_reset();
      rst            = 1'b0;
      bus.cpu_req    = 1'b0;
      bus.cpu_addr   = '0;
      bus.hit_status = 1'b0;
      bus.mem_ack    = 1'b0;
      bus2.cpu_req    = 1'b0;
      bus2.cpu_addr   = '0;
      bus2.hit_status = 1'b1;
      bus2.mem_ack    = 1'b0;

      #3 rst = 1'b1;
      #1;
      chk("rst_busy", bus.cpu_busy, 1'b0);
      chk("rst_done", bus.cpu_done, 1'b0);
      chk("rst_hit", bus.cpu_hit, 1'b0);
      chk("rst_memreq", bus.mem_req, 1'b0);
      chk("rst_write", wr_vec(), 4'b0000);
      chk("rst_index", bus.Index, 5'd0);
      chk("rst_tag", bus.Tag, 57'd0);
      chk("rst_hitcnt", bus.hit_cnt, 16'd0);
      chk("rst_misscnt", bus.miss_cnt, 16'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed hit and miss on the same address.
      txn(64'h0000_0000_0000_1234, 1'b1, 0, 1'b0);
      txn(64'h0000_0000_0000_1234, 1'b0, 3, 1'b0);

      // Round-robin on index 3 with an interleaved index-4 miss.
      for (int i = 0; i < 5; i++) begin
         a = {$urandom, $urandom};
         a[6:2] = 5'd3;
         txn(a, 1'b0, 1, 1'b0);
         if (i == 2) begin
            a[6:2] = 5'd4;
            txn(a, 1'b0, 0, 1'b0);
         end
      end

      // mem_ack while idle must not start anything.
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("idle_ack_busy", bus.cpu_busy, 1'b0);
      chk("idle_ack_write", wr_vec(), 4'b0000);
      chk("idle_ack_misscnt", bus.miss_cnt, m_miss);

      // Randomized traffic concentrated on a few indices, with protocol noise.
      for (int i = 0; i < 24; i++) begin
         a = {$urandom, $urandom};
         a[6:2] = 5'($urandom_range(0, 3));
         txn(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      // Reset during MISS_REQ abandons the fill and clears all pointers.
      a = 64'h0000_00AB_CDEF_0050;
      txn(a, 1'b0, 0, 1'b0);
      bus.cpu_addr   = a;
      bus.cpu_req    = 1'b1;
      bus.hit_status = 1'b0;
      @(negedge clk);
      bus.cpu_req = 1'b0;
      @(negedge clk);
      chk("pre_rst_memreq", bus.mem_req, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_memreq", bus.mem_req, 1'b0);
      chk("midrst_busy", bus.cpu_busy, 1'b0);
      chk("midrst_index", bus.Index, 5'd0);
      chk("midrst_misscnt", bus.miss_cnt, 16'd0);
      model_reset();
      bus.mem_ack = 1'b1;
      @(negedge clk);
      chk("midrst_write", wr_vec(), 4'b0000);
      chk("midrst_done", bus.cpu_done, 1'b0);
      rst = 1'b0;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      chk("postrst_write", wr_vec(), 4'b0000);
      chk("postrst_done", bus.cpu_done, 1'b0);
      txn(a, 1'b0, 2, 1'b0);

      // Saturation on a 2-bit counter instance.
      for (int i = 0; i < 4; i++) begin
         bus2.cpu_addr = {$urandom, $urandom};
         bus2.cpu_req  = 1'b1;
         @(negedge clk);
         bus2.cpu_req = 1'b0;
         @(negedge clk);
         chk("sat_done", bus2.cpu_done, 1'b1);
         chk("sat_hitcnt", bus2.hit_cnt, (i + 1 < 3) ? i + 1 : 3);
         @(negedge clk);
      end
      chk("sat_misscnt", bus2.miss_cnt, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/legv8_cache_ctrl.md
Name: legv8_cache_ctrl

Overview:
- Controller that sits directly upstream of the 4-way cache memory array.
- Accepts CPU lookup requests and splits the 64-bit address into tag, index and offset, which drive the array's Tag/Index inputs.
- Samples the array's hit_status. On a miss, fetches the block from main memory over a req/ack handshake, then pulses exactly one way-write strobe chosen by per-index round-robin replacement.
- Keeps hit and miss statistics counters.

Parameters:
- CNT_W, 16, width of hit/miss statistics counters (saturating).
- NUM_IDX, 32, number of index lines; index width fixed at 5.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  lookup request; sampled only in IDLE.
- cpu_addr  in  64  byte address of request.
- cpu_busy  out  1  high in any state other than IDLE.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_hit  out  1  valid with cpu_done: 1 = hit, 0 = miss-filled.
- Index  out  5  to cache array; equals latched_addr[6:2].
- Tag  out  57  to cache array; equals latched_addr[63:7].
- hit_status  in  1  from cache array, combinational on Index/Tag.
- Write0, Write1, Write2, Write3  out  1 each  way write strobes to the cache array.
- mem_req  out  1  main-memory fetch request.
- mem_addr  out  64  block address {latched_addr[63:2], 2'b00}.
- mem_ack  in  1  fetch complete.
- hit_cnt  out  CNT_W  number of hits.
- miss_cnt  out  CNT_W  number of misses.

Behaviour:
- Address split:
  - Tag = addr[63:7]
  - Index = addr[6:2]
  - offset = addr[1:0], unused by the controller.
- FSM states: IDLE, LOOKUP, MISS_REQ, FILL, DONE.
- IDLE:
  - On cpu_req = 1, latch cpu_addr and go to LOOKUP.
  - Otherwise stay in IDLE.
- LOOKUP (one cycle):
  - Index/Tag reflect the latched address.
  - hit_status = 1: go to DONE with cpu_hit = 1; hit_cnt += 1.
  - hit_status = 0: go to MISS_REQ; miss_cnt += 1.
- MISS_REQ:
  - mem_req = 1 and mem_addr valid; hold until mem_ack is sampled high.
  - On mem_ack, go to FILL.
  - mem_req is low in every other state.
- FILL (one cycle):
  - Exactly one of Write0..3 is high: way = rr_ptr[Index].
  - rr_ptr[Index] increments modulo 4 (3 wraps to 0).
  - Go to DONE with cpu_hit = 0.
- DONE (one cycle): cpu_done = 1, then go to IDLE.
- Latency, counting the cycle in which cpu_req is sampled as cycle 0:
  - Hit: cpu_done is high in cycle 2.
  - Miss: cpu_done is high 2 cycles after the cycle mem_ack is sampled.
- Write0..3 are never high outside FILL. At most one strobe is high in any cycle.
- rr_ptr: 32 entries x 2 bits, independent per index. Updated only in FILL.
- cpu_req outside IDLE is ignored; no queueing. A request held high through DONE is taken as a new request in the following IDLE cycle.
- mem_ack outside MISS_REQ is ignored.
- Counters saturate at all-ones; no wrap.
- cpu_hit holds its last value after DONE until the next DONE.
- Reset values, asynchronous with rst high, including mid-operation:
  - State returns to IDLE.
  - Outputs: cpu_busy, cpu_done, cpu_hit, mem_req, Write0..3 = 0.
  - Latched address = 0, so Index = 0 and Tag = 0.
  - hit_cnt and miss_cnt = 0; all rr_ptr entries = 0.
  - A fill in progress is abandoned: no write strobe and no cpu_done.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately, FSM in IDLE, counters 0.
- Hit: cpu_addr = 0x0000_0000_0000_1234, hit_status forced 1 -> Index = 5'h0D, Tag = 57'h24, cpu_done = 1 and cpu_hit = 1 in cycle 2, hit_cnt = 1, no Write strobe, mem_req never high.
- Miss: same address, hit_status = 0, mem_ack returned 3 cycles after mem_req rises -> mem_addr = 0x...1234, Write0 pulses for one cycle, then cpu_done = 1 with cpu_hit = 0; miss_cnt = 1.
- Round-robin: five misses to Index 3 -> strobes Write0, Write1, Write2, Write3, Write0. An interleaved miss to Index 4 -> Write0, confirming per-index pointers are independent.
- Reset during MISS_REQ (mem_req high, mem_ack never given) -> mem_req drops asynchronously, no Write strobe, no cpu_done. A subsequent miss to the same index uses Write0.
- Protocol noise: cpu_req pulses while busy, and mem_ack pulses in LOOKUP/IDLE -> ignored, no extra transactions or counter changes. With CNT_W = 2, four hits -> hit_cnt saturates at 3.
